// File: rtl/code_conv_arbiter.sv
// -----------------------------------------------------------------------------
// code_conv_arbiter
//
// Round-robin scheduler that shares one 4-bit code converter (BCD, Gray,
// even-parity Hamming(7,4)) among N_REQ requesters. Each transaction runs
// through three states:
//   IDLE - grant one requester and capture its operand,
//   CONV - convert and register the result,
//   RESP - present the result until the consumer accepts it.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset
//   req_valid  - per-requester request strobe                 [N_REQ]
//   req_ready  - one-hot grant, only in IDLE                  [N_REQ]
//   req_data   - operands, requester i at [4i+3:4i]           [4*N_REQ]
//   req_mode   - code select, requester i at [2i+1:2i]        [2*N_REQ]
//                (00 BCD, 01 Gray, 10 Hamming, 11 reserved)
//   rsp_valid  - result available (state RESP)
//   rsp_ready  - consumer accepts the result
//   rsp_data   - converted code, zero-extended to 7 bits
//   rsp_id     - index of the requester that was served
//   rsp_err    - operand > 9 or reserved mode
//   busy       - state is not IDLE
// -----------------------------------------------------------------------------
module code_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_data,
    input  logic [2*N_REQ-1:0]   req_mode,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [6:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_gnt_id;
    logic [3:0]      r_opnd;
    logic [1:0]      r_mode;
    logic [6:0]      r_rsp_data;
    logic [ID_W-1:0] r_rsp_id;
    logic            r_rsp_err;

    logic [3:0]      w_data [N_REQ];
    logic [1:0]      w_mode [N_REQ];
    logic [N_REQ-1:0] w_rot;
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_win;
    logic            w_any;
    logic            w_grant_en;
    logic [6:0]      w_code;
    logic            w_err;

    // Unpack the flat request buses and drive the one-hot grant.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_data[gi]    = req_data[4*gi +: 4];
            assign w_mode[gi]    = req_mode[2*gi +: 2];
            assign req_ready[gi] = w_grant_en && (w_win == ID_W'(gi));
        end
    endgenerate

    // Round-robin pick: rotate the request vector so r_ptr lands at bit 0,
    // find the lowest set bit, then rotate the offset back (mod N_REQ).
    always_comb begin
        w_rot = N_REQ'({req_valid, req_valid} >> r_ptr);
        w_any = |req_valid;
        w_sum = {1'b0, r_ptr};
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_sum = {1'b0, r_ptr} + (ID_W+1)'(j);
            end
        end
        if (w_sum >= (ID_W+1)'(N_REQ)) begin
            w_win = ID_W'(w_sum - (ID_W+1)'(N_REQ));
        end else begin
            w_win = ID_W'(w_sum);
        end
    end

    // Converter operates on the captured operand only.
    always_comb begin
        w_err  = (r_opnd > 4'd9) || (r_mode == 2'b11);
        w_code = 7'd0;
        if (!w_err) begin
            case (r_mode)
                2'b00:   w_code = {3'b000, r_opnd};
                2'b01:   w_code = {3'b000, r_opnd ^ (r_opnd >> 1)};
                2'b10:   w_code = {r_opnd[3], r_opnd[2], r_opnd[1],
                                   r_opnd[1] ^ r_opnd[2] ^ r_opnd[3],
                                   r_opnd[0],
                                   r_opnd[0] ^ r_opnd[2] ^ r_opnd[3],
                                   r_opnd[0] ^ r_opnd[1] ^ r_opnd[3]};
                default: w_code = 7'd0;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and outputs. Grants are masked while rst_n is low so
    // no requester sees a handshake on a reset edge.
    always_comb begin
        w_state_next = r_state;
        w_grant_en   = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy       = 1'b0;
                w_grant_en = w_any && rst_n;
                if (w_any) begin
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, register the result in CONV, advance the
    // round-robin pointer past the served requester on the response handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_gnt_id   <= '0;
            r_opnd     <= '0;
            r_mode     <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_grant_en) begin
                r_opnd   <= w_data[w_win];
                r_mode   <= w_mode[w_win];
                r_gnt_id <= w_win;
            end
            if (r_state == S_CONV) begin
                r_rsp_data <= w_code;
                r_rsp_err  <= w_err;
                r_rsp_id   <= r_gnt_id;
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_ptr <= (r_gnt_id == ID_W'(N_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
            end
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_rsp_id;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_code_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_code_conv_arbiter
//
// Self-checking bench for code_conv_arbiter with N_REQ = 4. Directed
// scenarios plus randomized traffic checked against a behavioural model:
// conversion from the code definitions (Hamming built from parity groups over
// codeword positions 1..7) and round-robin order from a scan over requesters.
// -----------------------------------------------------------------------------
module tb_code_conv_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_data = '0;
    logic [2*N-1:0] req_mode = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [6:0]     rsp_data;
    logic [1:0]     rsp_id;
    logic           rsp_err;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    code_conv_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic [3:0] d, input logic [1:0] m);
        return (d > 4'd9) || (m == 2'd3);
    endfunction

    function automatic logic [6:0] ref_code(input logic [3:0] d, input logic [1:0] m);
        logic [7:1] cw;
        logic       par;
        if (ref_err(d, m)) return 7'd0;
        if (m == 2'd0) return {3'b000, d};
        if (m == 2'd1) return {3'b000, d ^ {1'b0, d[3:1]}};
        // Hamming: data at positions 3,5,6,7; parity at 1,2,4 covers every
        // position whose index has that parity bit's weight set.
        cw = '0;
        cw[3] = d[0]; cw[5] = d[1]; cw[6] = d[2]; cw[7] = d[3];
        for (int p = 0; p < 3; p++) begin
            par = 1'b0;
            for (int pos = 1; pos < 8; pos++) begin
                if (pos[p]) par = par ^ cw[pos];
            end
            cw[1 << p] = par;
        end
        return cw[7:1];
    endfunction

    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic [3:0] d, input logic [1:0] m);
        req_valid[id]        = v;
        req_data[4*id +: 4]  = d;
        req_mode[2*id +: 2]  = m;
    endtask

    task automatic randomize_reqs();
        logic [N-1:0] mask;
        mask = N'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) begin
            set_req(i, mask[i], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (|req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        step();
        step();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (rsp_data !== 7'd0) begin errors++; $display("FAIL reset_rsp_data: got %h exp 00", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d exp 0", rsp_id); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b exp 0", rsp_err); end
        req_valid = '0;
        rst_n = 1'b1;
        ptr_m = 0;
        step();
    endtask

    task automatic test_directed(input int id, input logic [3:0] d, input logic [1:0] m,
                                 input logic [6:0] exp_d, input logic exp_e, input string name);
        bit ok;
        req_valid = '0;
        set_req(id, 1'b1, d, m);
        rsp_ready = 1'b1;
        wait_grant(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL %s_grant: got no grant exp grant within 20 cycles", name);
            req_valid = '0;
            return;
        end
        checks++; if (req_ready !== 4'(1 << id)) begin errors++; $display("FAIL %s_ready: got %b exp %b", name, req_ready, 4'(1 << id)); end
        step();
        req_valid = '0;
        checks++; if ({rsp_valid, busy} !== 2'b01) begin errors++; $display("FAIL %s_conv: got valid/busy %b exp 01", name, {rsp_valid, busy}); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b exp 1", name, rsp_valid); end
        checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL %s_data: got %h exp %h", name, rsp_data, exp_d); end
        checks++; if (rsp_id !== 2'(id)) begin errors++; $display("FAIL %s_id: got %0d exp %0d", name, rsp_id, id); end
        checks++; if (rsp_err !== exp_e) begin errors++; $display("FAIL %s_err: got %b exp %b", name, rsp_err, exp_e); end
        $display("txn %s: id=%0d data=%h err=%b", name, rsp_id, rsp_data, rsp_err);
        step();
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL %s_done: got valid/busy %b exp 00", name, {rsp_valid, busy}); end
        ptr_m = (id + 1) % N;
    endtask

    task automatic test_fairness();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int w;
        bit ok;
        logic [3:0] d;
        logic [1:0] m;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ptr_m = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        for (int n = 0; n < 5; n++) begin
            w = rr_pick(req_valid, ptr_m);
            d = req_data[4*w +: 4];
            m = req_mode[2*w +: 2];
            wait_grant(ok);
            checks++; if (!ok) begin errors++; $display("FAIL fair_grant: got no grant exp grant (service %0d)", n); break; end
            checks++; if (!$onehot(req_ready)) begin errors++; $display("FAIL fair_onehot: got %b exp one-hot", req_ready); end
            checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL fair_ready: got %b exp %b", req_ready, 4'(1 << w)); end
            step();
            set_req(w, 1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            step();
            checks++; if (rsp_id !== 2'(exp_seq[n])) begin errors++; $display("FAIL fair_id: got %0d exp %0d", rsp_id, exp_seq[n]); end
            checks++; if (rsp_data !== ref_code(d, m)) begin errors++; $display("FAIL fair_data: got %h exp %h", rsp_data, ref_code(d, m)); end
            checks++; if (rsp_err !== ref_err(d, m)) begin errors++; $display("FAIL fair_err: got %b exp %b", rsp_err, ref_err(d, m)); end
            $display("txn fair: id=%0d data=%h err=%b", rsp_id, rsp_data, rsp_err);
            step();
            ptr_m = (w + 1) % N;
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [6:0] ed;
        ed = ref_code(4'd6, 2'd1);
        req_valid = '0;
        set_req(1, 1'b1, 4'd6, 2'd1);
        rsp_ready = 1'b1;
        wait_grant(ok);
        checks++; if (!ok || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b exp 0010", req_ready); end
        step();
        set_req(0, 1'b1, 4'd1, 2'd0);
        set_req(2, 1'b1, 4'd2, 2'd0);
        set_req(3, 1'b1, 4'd3, 2'd0);
        rsp_ready = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) rsp_ready = 1'b1;
            #1;
            checks++; if ({rsp_valid, busy} !== 2'b11) begin errors++; $display("FAIL bp_valid: got valid/busy %b exp 11 (cycle %0d)", {rsp_valid, busy}, i); end
            checks++; if ({rsp_data, rsp_id, rsp_err} !== {ed, 2'd1, 1'b0}) begin errors++; $display("FAIL bp_hold: got data=%h id=%0d err=%b exp data=%h id=1 err=0", rsp_data, rsp_id, rsp_err, ed); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready: got %b exp 0000", req_ready); end
            if (i == 5) req_valid = '0;
            step();
        end
        $display("txn backpressure: id=%0d data=%h err=%b", rsp_id, rsp_data, rsp_err);
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release: got valid/busy %b exp 00", {rsp_valid, busy}); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_single: got %b exp 0", rsp_valid); end
        ptr_m = 2;
    endtask

    task automatic test_mid_reset();
        bit ok;
        logic [3:0] d;
        logic [1:0] m;
        req_valid = '0;
        rsp_ready = 1'b1;
        set_req(2, 1'b1, 4'd5, 2'd2);
        wait_grant(ok);
        step();
        req_valid = '0;
        step();
        step();
        set_req(3, 1'b1, 4'd4, 2'd0);
        wait_grant(ok);
        checks++; if (!ok || req_ready !== 4'b1000) begin errors++; $display("FAIL mr_grant3: got %b exp 1000", req_ready); end
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mr_resp: got %b exp 1", rsp_valid); end
        rst_n = 1'b0;
        req_valid = '1;
        step();
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL mr_after: got valid/busy %b exp 00", {rsp_valid, busy}); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mr_ready_in_reset: got %b exp 0000", req_ready); end
        rst_n = 1'b1;
        ptr_m = 0;
        rsp_ready = 1'b1;
        d = req_data[3:0];
        m = req_mode[1:0];
        #1;
        checks++; if (req_ready !== 4'(1 << rr_pick(req_valid, ptr_m))) begin errors++; $display("FAIL mr_first_grant: got %b exp %b", req_ready, 4'(1 << rr_pick(req_valid, ptr_m))); end
        step();
        req_valid = '0;
        step();
        checks++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd0}) begin errors++; $display("FAIL mr_rsp_id: got valid=%b id=%0d exp valid=1 id=0", rsp_valid, rsp_id); end
        checks++; if (rsp_data !== ref_code(d, m)) begin errors++; $display("FAIL mr_rsp_data: got %h exp %h", rsp_data, ref_code(d, m)); end
        $display("txn mid_reset: id=%0d data=%h err=%b", rsp_id, rsp_data, rsp_err);
        step();
        ptr_m = 1;
    endtask

    task automatic test_random();
        int w;
        int k;
        bit ok;
        logic [6:0] ed;
        logic ee;
        randomize_reqs();
        for (int n = 0; n < 40; n++) begin
            w  = rr_pick(req_valid, ptr_m);
            ed = ref_code(req_data[4*w +: 4], req_mode[2*w +: 2]);
            ee = ref_err(req_data[4*w +: 4], req_mode[2*w +: 2]);
            rsp_ready = 1'b0;
            wait_grant(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_grant: got no grant exp grant (txn %0d)", n); break; end
            checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL rand_ready: got %b exp %b", req_ready, 4'(1 << w)); end
            step();
            randomize_reqs();
            k = $urandom_range(0, 3);
            #1;
            checks++; if ({rsp_valid, busy, req_ready} !== {2'b01, 4'b0000}) begin errors++; $display("FAIL rand_conv: got valid=%b busy=%b ready=%b exp 0 1 0000", rsp_valid, busy, req_ready); end
            step();
            for (int i = 0; i <= k; i++) begin
                checks++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL rand_resp: got valid=%b ready=%b exp 1 0000", rsp_valid, req_ready); end
                checks++; if ({rsp_data, rsp_id, rsp_err} !== {ed, 2'(w), ee}) begin errors++; $display("FAIL rand_result: got data=%h id=%0d err=%b exp data=%h id=%0d err=%b", rsp_data, rsp_id, rsp_err, ed, w, ee); end
                rsp_ready = (i == k);
                step();
            end
            $display("txn rand %0d: id=%0d data=%h err=%b stall=%0d", n, w, ed, ee, k);
            ptr_m = (w + 1) % N;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_directed(2, 4'd5,  2'b10, 7'h2D, 1'b0, "hamming");
        test_directed(0, 4'd7,  2'b01, 7'h04, 1'b0, "gray");
        test_directed(0, 4'd9,  2'b00, 7'h09, 1'b0, "bcd");
        test_directed(1, 4'd12, 2'b00, 7'h00, 1'b1, "err_range");
        test_directed(3, 4'd3,  2'b11, 7'h00, 1'b1, "err_mode");
        test_fairness();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
